mult_chain_iter: RTL
====================

Name: mult_chain_iter

Overview:
- Parametrised, unsigned, multi-operand multiplier that computes the product of NUM_IN operands of WIDTH bits each.
- Multiplies iteratively, one operand per clock, through a single full-width accumulator.
- Adds valid/ready handshakes on both sides, a configurable result width, saturate/wrap mode and an overflow flag.
- Successor to the single-cycle registered 1-bit product stage; sits between upstream operand producers and downstream consumers that may apply backpressure.

Parameters:
- WIDTH, 8, bit width of each operand (>=1).
- NUM_IN, 5, number of operands multiplied together (>=1).
- OUT_WIDTH, 16, result width (1..WIDTH*NUM_IN).
- SAT, 0, overflow handling: 1 = saturate result to all-ones; 0 = truncate to low OUT_WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle.
- in_ops  input  WIDTH*NUM_IN  packed operands; op[i] = in_ops[i*WIDTH +: WIDTH], op[0] in the LSBs.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  OUT_WIDTH  product (saturated or truncated).
- out_ovf  output  1  full product exceeded 2^OUT_WIDTH-1.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - state=IDLE, accumulator=0, operand latch=0, count=0.
  - out_valid=0, out_data=0, out_ovf=0, in_ready=1 (combinational from state).
- Arithmetic:
  - Accumulator width is P=WIDTH*NUM_IN; it never truncates internally.
  - out_ovf=1 when accumulator > 2^OUT_WIDTH-1.
  - SAT=1: out_data = all-ones on overflow, else low OUT_WIDTH bits.
  - SAT=0: out_data = low OUT_WIDTH bits always.
  - out_data and out_ovf are registered and valid only with out_valid. When OUT_WIDTH=P, out_ovf is constant 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch all of in_ops, set acc=op[0] and count=1. Go to MULT, or to DONE if NUM_IN=1 (result registered on the same edge).
  - MULT: in_ready=0. Each edge: acc=acc*op[count], count++. On the edge where count==NUM_IN-1 is consumed, register out_data/out_ovf from the final product and go to DONE.
  - DONE: out_valid=1; out_data/out_ovf held stable until out_ready=1. in_ready=out_ready (pass-through accept).
    - On out_valid&out_ready without a new input: go to IDLE, out_valid=0.
    - On simultaneous in_valid&out_ready: complete the output handshake and load the new bundle on the same edge, as in IDLE. No bubble is inserted on the input side.
- Latency: out_valid rises exactly NUM_IN cycles after the accepting edge (edge k accept -> out_valid high after edge k+NUM_IN-1, sampled in cycle k+NUM_IN). Latency is independent of operand values. Throughput is one result per NUM_IN cycles with out_ready held 1.
- Backpressure: out_valid/out_data/out_ovf must not change while out_valid=1 and out_ready=0. in_valid is ignored while in_ready=0, and in_ops is never re-sampled mid-operation.
- in_ops may change freely after the accepting edge.
- Zero operands: no early exit; result 0, out_ovf=0.
- Reset mid-operation: rst_n low at any time immediately forces the reset state and drops any in-flight result. The first accept is possible on the first edge with rst_n high.

Test Plan:
- WIDTH=1,NUM_IN=5,OUT_WIDTH=1, in_ops=5'b11111 accepted at edge 0 -> out_valid in cycle 5, out_data=1, out_ovf=0. in_ops=5'b11011 -> out_data=0.
- WIDTH=8,NUM_IN=5,OUT_WIDTH=16, ops {3,5,7,2,4} -> out_data=840 (0x0348), out_ovf=0, latency 5.
- Same config, all ops=255:
  - SAT=1 -> out_data=0xFFFF, out_ovf=1.
  - SAT=0 -> out_data=0x04FF (1078203909375 mod 65536), out_ovf=1.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> out_data stable, in_ready=0, a new in_valid is not accepted. Raise out_ready with in_valid=1 -> both handshakes on one edge; next result out_valid 5 cycles later.
- Back-to-back: out_ready=1 and in_valid=1 continuously with ops {1,2,3,4,5} then {2,2,2,2,2} -> results 120 then 32, spaced 5 cycles apart.
- Reset mid-operation: assert rst_n=0 two cycles after accept -> out_valid=0 and in_ready=1 immediately (asynchronously). After release, a fresh bundle {1,1,1,1,9} -> 9 with normal latency.

Source files
------------

// File: rtl/mult_chain_iter.sv
// Iterative unsigned multi-operand multiplier: one operand folded into a full-width
// accumulator per clock, with valid/ready on both sides and saturate/wrap result shaping.
module mult_chain_iter #(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 5,
    parameter int OUT_WIDTH = 16,
    parameter int SAT       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*NUM_IN-1:0]   in_ops,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_ovf
);

    localparam int P  = WIDTH * NUM_IN;
    localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [P-1:0]           acc_q, acc_d;
    logic [P-1:0]           ops_q, ops_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   ovf_q, ovf_d;

    logic [WIDTH-1:0]       curOp;
    logic [P-1:0]           prod;
    logic [P-1:0]           finalProd;
    logic [OUT_WIDTH-1:0]   resData;
    logic                   resOvf;
    logic                   accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;
    assign accept    = in_valid && in_ready;

    // Operand picked by the running count from the latched bundle.
    always_comb begin
        curOp = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cnt_q == CW'(i)) begin
                curOp = ops_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // The running product always fits in P bits, so this never loses information.
    assign prod      = acc_q * P'(curOp);
    assign finalProd = (state_q == MULT) ? prod : P'(in_ops[WIDTH-1:0]);

    generate
        if (OUT_WIDTH < P) begin : g_ovf
            assign resOvf = |finalProd[P-1:OUT_WIDTH];
        end else begin : g_noovf
            assign resOvf = 1'b0;
        end
    endgenerate

    assign resData = ((SAT != 0) && resOvf) ? {OUT_WIDTH{1'b1}} : finalProd[OUT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ops_d   = ops_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    ops_d = in_ops;
                    acc_d = P'(in_ops[WIDTH-1:0]);
                    cnt_d = CW'(1);
                    if (NUM_IN == 1) begin
                        state_d = DONE;
                        data_d  = resData;
                        ovf_d   = resOvf;
                    end else begin
                        state_d = MULT;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            MULT: begin
                acc_d = prod;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_IN - 1)) begin
                    state_d = DONE;
                    data_d  = resData;
                    ovf_d   = resOvf;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ops_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ops_q   <= ops_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
